// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a byte FIFO in front of it.
// Sends 5..8 data bits LSB first, with optional even/odd parity and one or two
// stop bits. Bytes queue in the FIFO so the register side can burst writes.
// When the FIFO still holds data at the end of a frame, the next frame starts
// on the following cycle with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit time (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2, >= 2)
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Tx_DV       write strobe; byte taken when i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte     data byte; bits above the data width are ignored
//   i_Data_Bits   data width: 00=5, 01=6, 10=7, 11=8
//   i_Parity_En   append a parity bit after the data
//   i_Parity_Odd  0 = even parity, 1 = odd parity
//   i_Two_Stop    0 = one stop bit, 1 = two stop bits
//   o_Tx_Ready    FIFO not full (combinational from the count)
//   o_Fifo_Count  bytes queued, not counting the frame in flight
//   o_Tx_Active   high from the first start-bit cycle to the last stop-bit cycle
//   o_Tx_Serial   serial line, idle high
//   o_Tx_Done     one-cycle pulse at the end of each frame

module uart_tx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                         i_Clock,
  input  logic                         i_Rst_n,
  input  logic                         i_Tx_DV,
  input  logic [7:0]                   i_Tx_Byte,
  input  logic [1:0]                   i_Data_Bits,
  input  logic                         i_Parity_En,
  input  logic                         i_Parity_Odd,
  input  logic                         i_Two_Stop,
  output logic                         o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]  o_Fifo_Count,
  output logic                         o_Tx_Active,
  output logic                         o_Tx_Serial,
  output logic                         o_Tx_Done
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned BIT_CNT_W = $clog2(CLKS_PER_BIT);

  // Per-frame settings, captured when the byte leaves the FIFO.
  typedef struct packed {
    logic [7:0] data;      // byte with bits above the data width cleared
    logic [2:0] last_idx;  // index of the last data bit (DB-1)
    logic       par_en;
    logic       par_bit;   // precomputed parity bit for this frame
    logic       two_stop;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and control
  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  // Transmitter state
  state_t               state;
  frame_t               frame;
  logic [BIT_CNT_W-1:0] clk_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;

  // Combinational helpers
  logic                 push_c;
  logic                 pop_c;
  logic                 bit_end_c;
  logic                 frame_end_c;
  logic [7:0]           head_c;
  logic [7:0]           mask_c;
  logic [7:0]           masked_c;
  frame_t               next_frame_c;

  assign o_Tx_Ready   = (count != CNT_W'(FIFO_DEPTH));
  assign o_Fifo_Count = count;

  // A full FIFO refuses the write even if a pop happens on the same edge.
  assign push_c      = i_Tx_DV && (count != CNT_W'(FIFO_DEPTH));
  assign bit_end_c   = (clk_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
  assign frame_end_c = (state == S_STOP) && bit_end_c && (!frame.two_stop || stop_idx);
  // Pop whenever idle, or at the last stop-bit edge so frames run back to back.
  assign pop_c       = (count != '0) && ((state == S_IDLE) || frame_end_c);

  // Frame settings for the byte at the FIFO head, taken from the live config.
  always_comb begin
    head_c                = fifo_mem[rd_ptr];
    mask_c                = 8'hFF >> (2'd3 - i_Data_Bits);
    masked_c              = head_c & mask_c;
    next_frame_c          = '0;
    next_frame_c.data     = masked_c;
    next_frame_c.last_idx = 3'd4 + 3'(i_Data_Bits);
    next_frame_c.par_en   = i_Parity_En;
    next_frame_c.par_bit  = (^masked_c) ^ i_Parity_Odd;
    next_frame_c.two_stop = i_Two_Stop;
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge i_Clock) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= i_Tx_Byte;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM with registered line, active and done outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      frame       <= '0;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          if (pop_c) begin
            frame       <= next_frame_c;
            clk_cnt     <= '0;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= S_START;
          end
        end

        S_START: begin
          if (bit_end_c) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= frame.data[0];
            state       <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + BIT_CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end_c) begin
            clk_cnt <= '0;
            if (bit_idx == frame.last_idx) begin
              if (frame.par_en) begin
                o_Tx_Serial <= frame.par_bit;
                state       <= S_PARITY;
              end else begin
                o_Tx_Serial <= 1'b1;
                stop_idx    <= 1'b0;
                state       <= S_STOP;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= frame.data[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + BIT_CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end_c) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= 1'b1;
            stop_idx    <= 1'b0;
            state       <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + BIT_CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end_c) begin
            clk_cnt <= '0;
            if (!frame_end_c) begin
              stop_idx <= 1'b1;
            end else begin
              o_Tx_Done <= 1'b1;
              if (pop_c) begin
                // Next frame starts immediately; active stays high.
                frame       <= next_frame_c;
                o_Tx_Serial <= 1'b0;
                state       <= S_START;
              end else begin
                o_Tx_Serial <= 1'b1;
                o_Tx_Active <= 1'b0;
                state       <= S_IDLE;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + BIT_CNT_W'(1);
          end
        end

        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
